// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stage enables, bubbles and flushes
// for load-use stalls, EX redirects and data-memory waits, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  localparam int unsigned LU_W   = (LU_BUBBLES > 2) ? $clog2(LU_BUBBLES - 1) : 1;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned LU_INIT = (LU_BUBBLES > 1) ? (LU_BUBBLES - 2) : 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_nxt;
  logic              flush_inc;
  logic              timeout_hit;
  logic              run_eval;

  logic load_use, mem_busy, redirect;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mem_busy = mem_req && !mem_ready;
  assign redirect = ex_branch_taken || ex_jump;

  // Next state and stage controls; MEM_WAIT with a completed access reuses RUN's decision.
  always_comb begin
    state_nxt    = state_q;
    lu_cnt_nxt   = lu_cnt_q;
    wait_cnt_nxt = wait_cnt_q;
    flush_inc    = 1'b0;
    run_eval     = 1'b0;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      LU_STALL: begin
        if (mem_busy) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (lu_cnt_q == '0) begin
            state_nxt = RUN;
          end else begin
            lu_cnt_nxt = lu_cnt_q - LU_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
          if (wait_cnt_q != '1) begin
            wait_cnt_nxt = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_flush  = 1'b1;
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = WAIT_W'(1);
      end else if (redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
        state_nxt  = RUN;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        if (LU_BUBBLES > 1) begin
          state_nxt  = LU_STALL;
          lu_cnt_nxt = LU_W'(LU_INIT);
        end else begin
          state_nxt = RUN;
        end
      end else begin
        state_nxt = RUN;
      end
    end

    timeout_hit = (state_nxt == MEM_WAIT) && (wait_cnt_nxt >= WAIT_W'(MEM_TIMEOUT));

    // Reset forces every stage to hold and load bubbles.
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      lu_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt;
      lu_cnt_q   <= lu_cnt_nxt;
      wait_cnt_q <= wait_cnt_nxt;
    end
  end

  // Saturating counters and sticky timeout; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      if (!pc_we && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign state_o = 2'(state_q);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table on a default instance and
// hand sequences on a LU_BUBBLES=3 / MEM_TIMEOUT=4 / CNT_W=4 instance.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       ex_jump;
    logic       mem_req;
    logic       mem_ready;
    logic       cnt_clr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] ctrl;
    logic [1:0] st;
    int         stall;
    int         flush;
  } vec_t;

  // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush}
  localparam logic [6:0] C_DEF = 7'b1111_000;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_RDR = 7'b1111_110;
  localparam logic [6:0] C_RST = 7'b0000_111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_branch_taken, ex_jump;
  logic       mem_req, mem_ready, cnt_clr;

  logic        pc_we_a, ifid_we_a, idex_we_a, exmem_we_a;
  logic        ifid_flush_a, idex_flush_a, memwb_flush_a, mem_timeout_a;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  state_a;

  logic        pc_we_b, ifid_we_b, idex_we_b, exmem_we_b;
  logic        ifid_flush_b, idex_flush_b, memwb_flush_b, mem_timeout_b;
  logic [3:0]  stall_b, flush_b;
  logic [1:0]  state_b;

  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_we_a, ifid_we_a, idex_we_a, exmem_we_a, ifid_flush_a, idex_flush_a, memwb_flush_a};
  assign ctrl_b = {pc_we_b, ifid_we_b, idex_we_b, exmem_we_b, ifid_flush_b, idex_flush_b, memwb_flush_b};

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .idex_we(idex_we_a), .exmem_we(exmem_we_a),
    .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .memwb_flush(memwb_flush_a),
    .stall_cycles(stall_a), .flush_events(flush_a), .mem_timeout(mem_timeout_a),
    .state_o(state_a)
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .idex_we(idex_we_b), .exmem_we(exmem_we_b),
    .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .memwb_flush(memwb_flush_b),
    .stall_cycles(stall_b), .flush_events(flush_b), .mem_timeout(mem_timeout_b),
    .state_o(state_b)
  );

  function automatic in_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic ur, logic mr,
                             logic [4:0] ert, logic bt, logic j, logic mq, logic md, logic cc);
    in_t v;
    v = '{r, rs, rt, ur, mr, ert, bt, j, mq, md, cc};
    return v;
  endfunction

  // Drive on the falling edge, sample 2 time units later (well before the rising edge).
  task automatic apply(input in_t v);
    @(negedge clk);
    rst = v.rst; id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
    ex_memread = v.ex_memread; ex_rt = v.ex_rt; ex_branch_taken = v.ex_branch_taken;
    ex_jump = v.ex_jump; mem_req = v.mem_req; mem_ready = v.mem_ready; cnt_clr = v.cnt_clr;
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  vec_t tbl[25];
  in_t  v_idle, v_rst, v_lu, v_busy, v_ready, v_jump, v_clr;

  initial begin
    v_idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_rst   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_lu    = mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    v_busy  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v_ready = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v_jump  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v_clr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = '{v_rst,                                 C_RST, 2'd0, 0, 0};
    tbl[1]  = '{v_lu,                                  C_LU,  2'd0, 0, 0};
    tbl[2]  = '{v_idle,                                C_DEF, 2'd0, 1, 0};
    tbl[3]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),   C_DEF, 2'd0, 1, 0};
    tbl[4]  = '{mk(0, 3, 5, 0, 1, 5, 0, 0, 0, 0, 0),   C_DEF, 2'd0, 1, 0};
    tbl[5]  = '{mk(0, 3, 5, 1, 1, 5, 0, 0, 0, 0, 0),   C_LU,  2'd0, 1, 0};
    tbl[6]  = '{mk(0, 8, 0, 0, 1, 8, 1, 0, 0, 0, 0),   C_RDR, 2'd0, 2, 0};
    tbl[7]  = '{v_jump,                                C_RDR, 2'd0, 2, 1};
    tbl[8]  = '{v_busy,                                C_FRZ, 2'd0, 2, 2};
    tbl[9]  = '{v_busy,                                C_FRZ, 2'd2, 3, 2};
    tbl[10] = '{v_busy,                                C_FRZ, 2'd2, 4, 2};
    tbl[11] = '{v_busy,                                C_FRZ, 2'd2, 5, 2};
    tbl[12] = '{v_busy,                                C_FRZ, 2'd2, 6, 2};
    tbl[13] = '{v_ready,                               C_DEF, 2'd2, 7, 2};
    tbl[14] = '{v_idle,                                C_DEF, 2'd0, 7, 2};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0),   C_FRZ, 2'd0, 7, 2};
    tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0),   C_RDR, 2'd2, 8, 2};
    tbl[17] = '{v_clr,                                 C_DEF, 2'd0, 8, 3};
    tbl[18] = '{v_idle,                                C_DEF, 2'd0, 0, 0};
    tbl[19] = '{v_busy,                                C_FRZ, 2'd0, 0, 0};
    tbl[20] = '{mk(0, 8, 0, 0, 1, 8, 0, 0, 1, 1, 0),   C_LU,  2'd2, 1, 0};
    tbl[21] = '{mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0, 1),   C_LU,  2'd0, 2, 0};
    tbl[22] = '{v_idle,                                C_DEF, 2'd0, 0, 0};
    tbl[23] = '{mk(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0),   C_RST, 2'd0, 0, 0};
    tbl[24] = '{v_idle,                                C_DEF, 2'd0, 0, 0};

    apply(v_rst);
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].in);
      chk($sformatf("v%0d ctrl", i), 32'(ctrl_a), 32'(tbl[i].ctrl));
      chk($sformatf("v%0d state", i), 32'(state_a), 32'(tbl[i].st));
      chk($sformatf("v%0d stall_cycles", i), 32'(stall_a), 32'(tbl[i].stall));
      chk($sformatf("v%0d flush_events", i), 32'(flush_a), 32'(tbl[i].flush));
      chk($sformatf("v%0d mem_timeout", i), 32'(mem_timeout_a), 32'd0);
    end

    // Three load-use bubbles; a jump during the stall is ignored.
    apply(v_rst);
    apply(v_lu);
    chk("lu3 c0 ctrl", 32'(ctrl_b), 32'(C_LU));
    chk("lu3 c0 state", 32'(state_b), 32'd0);
    apply(v_jump);
    chk("lu3 c1 ctrl", 32'(ctrl_b), 32'(C_LU));
    chk("lu3 c1 state", 32'(state_b), 32'd1);
    apply(v_idle);
    chk("lu3 c2 ctrl", 32'(ctrl_b), 32'(C_LU));
    apply(v_idle);
    chk("lu3 c3 ctrl", 32'(ctrl_b), 32'(C_DEF));
    chk("lu3 c3 state", 32'(state_b), 32'd0);
    chk("lu3 stall_cycles", 32'(stall_b), 32'd3);
    chk("lu3 flush_events", 32'(flush_b), 32'd0);

    // Memory wait inside a load-use stall freezes and holds the bubble count.
    apply(v_rst);
    apply(v_lu);
    apply(v_busy);
    chk("lu_mem freeze ctrl", 32'(ctrl_b), 32'(C_FRZ));
    chk("lu_mem freeze state", 32'(state_b), 32'd1);
    apply(v_idle);
    chk("lu_mem c2 ctrl", 32'(ctrl_b), 32'(C_LU));
    apply(v_idle);
    chk("lu_mem c3 ctrl", 32'(ctrl_b), 32'(C_LU));
    apply(v_idle);
    chk("lu_mem c4 ctrl", 32'(ctrl_b), 32'(C_DEF));
    chk("lu_mem stall_cycles", 32'(stall_b), 32'd4);

    // Timeout: sticky past MEM_TIMEOUT wait cycles, cleared by cnt_clr.
    apply(v_rst);
    repeat (3) apply(v_busy);
    chk("to early", 32'(mem_timeout_b), 32'd0);
    repeat (3) apply(v_busy);
    chk("to busy ctrl", 32'(ctrl_b), 32'(C_FRZ));
    apply(v_ready);
    chk("to set", 32'(mem_timeout_b), 32'd1);
    chk("to ready ctrl", 32'(ctrl_b), 32'(C_DEF));
    chk("to ready state", 32'(state_b), 32'd2);
    apply(v_idle);
    chk("to sticky", 32'(mem_timeout_b), 32'd1);
    chk("to run state", 32'(state_b), 32'd0);
    apply(v_clr);
    apply(v_idle);
    chk("to cleared", 32'(mem_timeout_b), 32'd0);
    chk("to clr stall", 32'(stall_b), 32'd0);

    // Reset in the middle of memory wait and load-use stall.
    apply(v_busy);
    apply(v_busy);
    apply(v_rst);
    chk("rst mid-wait ctrl", 32'(ctrl_b), 32'(C_RST));
    apply(v_idle);
    chk("after rst-wait ctrl", 32'(ctrl_b), 32'(C_DEF));
    chk("after rst-wait state", 32'(state_b), 32'd0);
    apply(v_lu);
    apply(v_rst);
    apply(v_idle);
    chk("after rst-lu ctrl", 32'(ctrl_b), 32'(C_DEF));
    chk("after rst-lu state", 32'(state_b), 32'd0);

    // stall_cycles saturates at all-ones (4-bit counter).
    apply(v_rst);
    repeat (20) apply(v_busy);
    chk("sat stall_cycles", 32'(stall_b), 32'd15);
    apply(v_ready);
    chk("sat hold", 32'(stall_b), 32'd15);
    chk("sat ready state", 32'(state_b), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
